// File: rtl/spec_ram_arb_if.sv
// Bus bundle for spec_ram_arb: writer/reader request ports, read returns and the single-port RAM side.
// Handshake: a beat happens on each clk_50m edge where gnt and the matching req are both high; req may drop at any cycle.
interface spec_ram_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_gnt;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;

    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_gnt;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;
    logic [3:0]        dbg_state;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd0_req, rd0_addr, rd1_req, rd1_addr, ram_rdata,
        output wr_gnt, rd0_gnt, rd1_gnt, rd0_data, rd0_valid, rd1_data, rd1_valid,
        output ram_en, ram_we, ram_addr, ram_wdata, busy, dbg_state
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd0_req, rd0_addr, rd1_req, rd1_addr, ram_rdata,
        input  wr_gnt, rd0_gnt, rd1_gnt, rd0_data, rd0_valid, rd1_data, rd1_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata, busy, dbg_state
    );
endinterface

// File: rtl/spec_ram_arb.sv
// Spectrum RAM arbiter: one writer (fixed priority) and two round-robin readers share a single-port RAM.
// Optional per-grant beat limit enabled by defining SPEC_ARB_BURST_LIMIT_EN.
module spec_ram_arb #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 64
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    spec_ram_arb_if.slave bus
);
    if (RD_LAT < 1 || BURST_MAX < 1) begin : g_bad_param
        $error("spec_ram_arb: RD_LAT and BURST_MAX must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        GNT_W  = 4'b0010,
        GNT_R0 = 4'b0100,
        GNT_R1 = 4'b1000
    } state_t;

    state_t            state_q;
    logic              last_rd1_q;
    logic [RD_LAT-1:0] tag_v_q;
    logic [RD_LAT-1:0] tag_id_q;
    logic [DATA_W-1:0] rd0_data_q;
    logic [DATA_W-1:0] rd1_data_q;

    logic              wr_beat;
    logic              rd0_beat;
    logic              rd1_beat;
    logic              beat;
    logic              burst_done;
    logic              ret0;
    logic              ret1;
    logic [ADDR_W-1:0] ram_addr_mux;
    logic [DATA_W-1:0] ram_wdata_mux;

    assign wr_beat  = (state_q == GNT_W)  && bus.wr_req;
    assign rd0_beat = (state_q == GNT_R0) && bus.rd0_req;
    assign rd1_beat = (state_q == GNT_R1) && bus.rd1_req;
    assign beat     = wr_beat | rd0_beat | rd1_beat;

    always_comb begin
        ram_addr_mux  = '0;
        ram_wdata_mux = '0;
        if (wr_beat) begin
            ram_addr_mux  = bus.wr_addr;
            ram_wdata_mux = bus.wr_data;
        end else if (rd0_beat) begin
            ram_addr_mux  = bus.rd0_addr;
        end else if (rd1_beat) begin
            ram_addr_mux  = bus.rd1_addr;
        end
    end

    assign bus.ram_en    = beat;
    assign bus.ram_we    = wr_beat;
    assign bus.ram_addr  = ram_addr_mux;
    assign bus.ram_wdata = ram_wdata_mux;

`ifdef SPEC_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    logic [CNT_W-1:0] beat_cnt_q;
    logic             other_req;

    // Requests from anyone other than the current grant holder.
    assign other_req = (state_q == GNT_W)  ? (bus.rd0_req | bus.rd1_req) :
                       (state_q == GNT_R0) ? (bus.wr_req  | bus.rd1_req) :
                                             (bus.wr_req  | bus.rd0_req);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            beat_cnt_q <= '0;
        end else if (beat && (beat_cnt_q != CNT_W'(BURST_MAX))) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    assign burst_done = beat && other_req && (beat_cnt_q >= CNT_W'(BURST_MAX - 1));
`else
    assign burst_done = 1'b0;
`endif

    // Grant FSM; every grant passes through IDLE, which gives the bubble cycle.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_rd1_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_req) begin
                        state_q <= GNT_W;
                    end else if (bus.rd0_req && (!bus.rd1_req || last_rd1_q)) begin
                        state_q    <= GNT_R0;
                        last_rd1_q <= 1'b0;
                    end else if (bus.rd1_req) begin
                        state_q    <= GNT_R1;
                        last_rd1_q <= 1'b1;
                    end
                end
                GNT_W, GNT_R0, GNT_R1: begin
                    if (!beat || burst_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Requester tag travels alongside the RAM read latency.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q[0]  <= rd0_beat | rd1_beat;
            tag_id_q[0] <= rd1_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign ret0 = tag_v_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
    assign ret1 = tag_v_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data_q <= '0;
            rd1_data_q <= '0;
        end else begin
            if (ret0) rd0_data_q <= bus.ram_rdata;
            if (ret1) rd1_data_q <= bus.ram_rdata;
        end
    end

    assign bus.wr_gnt    = (state_q == GNT_W);
    assign bus.rd0_gnt   = (state_q == GNT_R0);
    assign bus.rd1_gnt   = (state_q == GNT_R1);
    assign bus.rd0_valid = ret0;
    assign bus.rd1_valid = ret1;
    assign bus.rd0_data  = ret0 ? bus.ram_rdata : rd0_data_q;
    assign bus.rd1_data  = ret1 ? bus.ram_rdata : rd1_data_q;
    assign bus.busy      = (state_q != IDLE) || (|tag_v_q);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spec_ram_arb.sv
// Directed bench for spec_ram_arb with a two-cycle-latency RAM model.
module tb_spec_ram_arb;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
`ifdef SPEC_ARB_BURST_LIMIT_EN
    localparam int EXP_BURST = 64;
`else
    localparam int EXP_BURST = 100;
`endif

    logic clk_50m;
    logic rst_n;
    int   checks;
    int   failures;
    logic [DATA_W-1:0] exp_q[$];

    spec_ram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spec_ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BURST_MAX(64)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // clock and watchdog
    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // RAM model: registered address stage plus registered data stage.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_p1;
    always @(posedge clk_50m) begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        rd_p1         <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr] : '0;
        bus.ram_rdata <= rd_p1;
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DATA_W-1:0] got);
        logic [DATA_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(got), 64'(e));
        end
    endtask

    task automatic drop_all();
        bus.wr_req  = 1'b0;
        bus.rd0_req = 1'b0;
        bus.rd1_req = 1'b0;
    endtask

    initial begin
        int seq[$];
        logic p0, p1, done0, done1, off0, off1;
        int b0, b1, beats, vcount;
        logic seen;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        drop_all();
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd0_addr = '0; bus.rd1_addr = '0;
        #25;
        check("rst_wr_gnt", 64'(bus.wr_gnt), 64'd0);
        check("rst_rd0_gnt", 64'(bus.rd0_gnt), 64'd0);
        check("rst_rd1_gnt", 64'(bus.rd1_gnt), 64'd0);
        check("rst_valid", 64'({bus.rd0_valid, bus.rd1_valid}), 64'd0);
        check("rst_data", 64'(bus.rd0_data | bus.rd1_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ram_en", 64'(bus.ram_en), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'h1);
        @(negedge clk_50m);
        rst_n = 1'b1;
        tick();

        // Round-robin with both readers continuously active, 4 beats each.
        p0 = 0; p1 = 0; done0 = 0; done1 = 0; off0 = 0; off1 = 0; b0 = 0; b1 = 0;
        bus.rd0_req = 1'b1; bus.rd1_req = 1'b1;
        for (int c = 0; c < 80 && seq.size() < 4; c++) begin
            tick();
            if (bus.rd0_gnt && !p0) seq.push_back(0);
            if (bus.rd1_gnt && !p1) seq.push_back(1);
            p0 = bus.rd0_gnt; p1 = bus.rd1_gnt;
            if (off0) begin bus.rd0_req = 1'b1; off0 = 0; end
            else if (done0) begin bus.rd0_req = 1'b0; off0 = 1; done0 = 0; b0 = 0; end
            if (off1) begin bus.rd1_req = 1'b1; off1 = 0; end
            else if (done1) begin bus.rd1_req = 1'b0; off1 = 1; done1 = 0; b1 = 0; end
            #1;
            if (bus.rd0_gnt && bus.rd0_req) begin b0++; if (b0 == 4) done0 = 1; end
            if (bus.rd1_gnt && bus.rd1_req) begin b1++; if (b1 == 4) done1 = 1; end
        end
        check("rr_grants", 64'(seq.size()), 64'd4);
        for (int i = 0; i < seq.size() && i < 4; i++) check($sformatf("rr_%0d", i), 64'(seq[i]), 64'(i % 2));
        drop_all();
        repeat (4) tick();

        // Writer priority over both readers, then rd0 after one bubble.
        bus.wr_req = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 32'h12345678;
        bus.rd0_req = 1'b1; bus.rd1_req = 1'b1; bus.rd0_addr = 12'd0; bus.rd1_addr = 12'd0;
        #1;
        check("pri_pre_gnt", 64'(bus.wr_gnt), 64'd0);
        tick();
        check("pri_wr_gnt", 64'(bus.wr_gnt), 64'd1);
        check("pri_rd_gnt", 64'({bus.rd0_gnt, bus.rd1_gnt}), 64'd0);
        check("wr_ram_en_we", 64'({bus.ram_en, bus.ram_we}), 64'h3);
        check("wr_ram_addr", 64'(bus.ram_addr), 64'd5);
        check("wr_ram_wdata", 64'(bus.ram_wdata), 64'h12345678);
        tick();
        bus.wr_req = 1'b0;
        #1;
        check("wr_release_en", 64'(bus.ram_en), 64'd0);
        tick();
        check("bubble_gnt", 64'({bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt}), 64'd0);
        tick();
        check("after_bubble_rd0", 64'({bus.rd0_gnt, bus.rd1_gnt}), 64'h2);
        drop_all();
        repeat (3) tick();

        // Read back address 5 through rd1.
        bus.rd1_req = 1'b1; bus.rd1_addr = 12'd5;
        tick();
        check("rd1_gnt", 64'(bus.rd1_gnt), 64'd1);
        check("rd1_ram_bus", 64'({bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}), 64'h200005);
        exp_q.push_back(32'h12345678);
        tick();
        bus.rd1_req = 1'b0;
        check("rd1_valid_early", 64'(bus.rd1_valid), 64'd0);
        tick();
        check("rd1_valid", 64'({bus.rd1_valid, bus.rd0_valid}), 64'h2);
        check_data("rd1_data", bus.rd1_data);
        tick();
        check("rd1_valid_end", 64'(bus.rd1_valid), 64'd0);
        check("rd1_data_hold", 64'(bus.rd1_data), 64'h12345678);
        check("busy_idle", 64'(bus.busy), 64'd0);

        // Read beat followed by a write grant while data is in flight.
        bus.rd0_req = 1'b1; bus.rd0_addr = 12'd5;
        tick();
        check("inflight_rd0_gnt", 64'(bus.rd0_gnt), 64'd1);
        bus.wr_req = 1'b1; bus.wr_addr = 12'd7; bus.wr_data = 32'hA5A5A5A5;
        exp_q.push_back(32'h12345678);
        tick();
        bus.rd0_req = 1'b0;
        check("inflight_busy_c", 64'(bus.busy), 64'd1);
        check("inflight_valid_c", 64'(bus.rd0_valid), 64'd0);
        tick();
        check("inflight_busy_d", 64'(bus.busy), 64'd1);
        check("inflight_rd0_valid", 64'(bus.rd0_valid), 64'd1);
        check_data("inflight_rd0_data", bus.rd0_data);
        tick();
        check("inflight_wr_gnt", 64'(bus.wr_gnt), 64'd1);
        check("inflight_busy_e", 64'(bus.busy), 64'd1);
        check("inflight_valid_e", 64'(bus.rd0_valid), 64'd0);
        bus.wr_req = 1'b0;
        repeat (2) tick();
        check("inflight_busy_end", 64'(bus.busy), 64'd0);

        // Long rd0 burst with the writer waiting.
        beats = 0; seen = 0;
        bus.rd0_req = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (bus.wr_gnt) begin
                seen = 1;
            end else begin
                if (bus.rd0_gnt) bus.wr_req = 1'b1;
                if (beats == 100) bus.rd0_req = 1'b0;
                #1;
                if (bus.rd0_gnt && bus.rd0_req) beats++;
            end
        end
        check("burst_switch_seen", 64'(seen), 64'd1);
        check("burst_beats", 64'(beats), 64'(EXP_BURST));
        check("burst_rd0_off", 64'(bus.rd0_gnt), 64'd0);
        drop_all();
        repeat (4) tick();

        // Reset one cycle after a read beat discards the read.
        bus.rd0_req = 1'b1; bus.rd0_addr = 12'd5;
        tick();
        tick();
        bus.rd0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_gnt", 64'({bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt}), 64'd0);
        check("midrst_data", 64'(bus.rd0_data), 64'd0);
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.rd0_valid || bus.rd1_valid) vcount++;
        end
        check("postrst_no_valid", 64'(vcount), 64'd0);
        check("postrst_gnt", 64'({bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt}), 64'd0);
        check("postrst_busy", 64'(bus.busy), 64'd0);
        check("postrst_ram", 64'({bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}), 64'd0);
        check("postrst_wdata", 64'(bus.ram_wdata), 64'd0);
        check("postrst_data", 64'(bus.rd0_data | bus.rd1_data), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
